uart_tx_scheduler: RTL

//  Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.

---
 rtl/uart_tx_scheduler_if.sv | 59 +++++
 rtl/uart_tx_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler_if
//   Bundle of signals between the byte producers, the UART TX wrapper and the
//   uart_tx_scheduler block.
//
//   Parameters
//     NUM_REQ     number of requesters (2..8)
//     DATA_WIDTH  byte width per requester and towards the transmitter
//
//   Signals
//     req_valid    [NUM_REQ]             per-requester byte pending
//     req_data     [NUM_REQ*DATA_WIDTH]  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_par_en   [NUM_REQ]             per-requester parity enable
//     req_par_typ  [NUM_REQ]             per-requester parity type (0 even, 1 odd)
//     req_ready    [NUM_REQ]             one-hot accept pulse
//     tx_data_valid                      launch strobe to the transmitter
//     tx_p_data    [DATA_WIDTH]          byte to the transmitter
//     tx_par_en / tx_par_typ             parity config to the transmitter
//     tx_busy                            transmitter busy flag
//     grant_id     [$clog2(NUM_REQ)]     current/last granted requester
//     active                             frame in flight
//     timeout_err                        transmitter never went busy
//
//   Modports
//     master  producers + transmitter side (drives requests and tx_busy)
//     slave   the scheduler itself
// ----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_par_en;
    logic [NUM_REQ-1:0]            req_par_typ;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          tx_data_valid;
    logic [DATA_WIDTH-1:0]         tx_p_data;
    logic                          tx_par_en;
    logic                          tx_par_typ;
    logic                          tx_busy;
    logic [GW-1:0]                 grant_id;
    logic                          active;
    logic                          timeout_err;

    modport master (
        output req_valid, req_data, req_par_en, req_par_typ, tx_busy,
        input  req_ready, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
               grant_id, active, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_par_en, req_par_typ, tx_busy,
        output req_ready, tx_data_valid, tx_p_data, tx_par_en, tx_par_typ,
               grant_id, active, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
//   Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
//   producers. One requester is granted per frame; its byte and parity config
//   are registered and launched with a single-cycle tx_data_valid pulse, then
//   the transmitter busy flag is tracked until the frame completes. If the
//   transmitter never raises tx_busy within BUSY_TIMEOUT cycles of launch, a
//   one-cycle timeout_err pulse is raised and the (already acknowledged) byte
//   is dropped.
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   uart_tx_scheduler_if.slave (requests, transmitter, status)
//
//   All outputs are registered. Timing of one frame:
//     IDLE (request seen) -> LAUNCH (tx_data_valid, req_ready, active)
//     -> WAIT_BUSY -> WAIT_DONE -> IDLE (next grant may happen here)
// ----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_scheduler_if.slave  bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [GW-1:0]           rr_ptr;
    logic [CW-1:0]           busy_cnt;
    logic [GW-1:0]           grant_id_q;
    logic [NUM_REQ-1:0]      req_ready_q;
    logic                    tx_data_valid_q;
    logic [DATA_WIDTH-1:0]   tx_p_data_q;
    logic                    tx_par_en_q;
    logic                    tx_par_typ_q;
    logic                    active_q;
    logic                    timeout_err_q;
    logic [GW-1:0]           pick;

    // First valid index at or after the pointer, wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [GW-1:0]      ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                sel   = GW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.req_valid, rr_ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            busy_cnt        <= '0;
            grant_id_q      <= '0;
            req_ready_q     <= '0;
            tx_data_valid_q <= 1'b0;
            tx_p_data_q     <= '0;
            tx_par_en_q     <= 1'b0;
            tx_par_typ_q    <= 1'b0;
            active_q        <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            tx_data_valid_q <= 1'b0;
            req_ready_q     <= '0;
            timeout_err_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if ((|bus.req_valid) && !bus.tx_busy) begin
                        grant_id_q      <= pick;
                        tx_p_data_q     <= bus.req_data[pick*DATA_WIDTH +: DATA_WIDTH];
                        tx_par_en_q     <= bus.req_par_en[pick];
                        tx_par_typ_q    <= bus.req_par_typ[pick];
                        tx_data_valid_q <= 1'b1;
                        req_ready_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        active_q        <= 1'b1;
                        state           <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    rr_ptr   <= (grant_id_q == GW'(NUM_REQ-1)) ? '0 : grant_id_q + GW'(1);
                    busy_cnt <= '0;
                    state    <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        busy_cnt <= busy_cnt + CW'(1);
                        // Decided one count early so the registered pulse lands
                        // in the cycle where the counter reads BUSY_TIMEOUT-1,
                        // i.e. BUSY_TIMEOUT cycles after launch.
                        if (busy_cnt == CW'(BUSY_TIMEOUT-2)) begin
                            timeout_err_q <= 1'b1;
                            active_q      <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        active_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant_id      = grant_id_q;
    assign bus.req_ready     = req_ready_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.tx_p_data     = tx_p_data_q;
    assign bus.tx_par_en     = tx_par_en_q;
    assign bus.tx_par_typ    = tx_par_typ_q;
    assign bus.active        = active_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule
